// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry type for the instruction fetch queue.
package fetch_pkg;
    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int PC_INC_DEF = 4;

    localparam int REG_W   = 5;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    // Sized to the default widths; narrower XLEN/ADDR_W are zero-extended into it.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [XLEN_DEF-1:0]   inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_unit_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch queue.
interface fetch_queue_unit_if #(
    parameter int XLEN   = fetch_pkg::XLEN_DEF,
    parameter int ADDR_W = fetch_pkg::ADDR_W_DEF
) ();
    logic                        redirect_valid;
    logic [ADDR_W-1:0]           redirect_pc;
    logic                        imem_req_valid;
    logic [ADDR_W-1:0]           imem_addr;
    logic [XLEN-1:0]             imem_rdata;
    logic                        de_valid;
    logic                        de_ready;
    logic [XLEN-1:0]             de_inst;
    logic [ADDR_W-1:0]           de_pc;
    logic [fetch_pkg::REG_W-1:0] de_rs1;
    logic [fetch_pkg::REG_W-1:0] de_rs2;
    logic [fetch_pkg::REG_W-1:0] de_rd;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, de_ready,
        output imem_req_valid, imem_addr, de_valid, de_inst, de_pc, de_rs1, de_rs2, de_rd
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, de_ready,
        input  imem_req_valid, imem_addr, de_valid, de_inst, de_pc, de_rs1, de_rs2, de_rd
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry queue of fetched {pc, inst} with flush and occupancy count.
module fetch_fifo import fetch_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);
    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is cleared on reset so the head reads zero, never X, while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: PC/credit control feeding a small decode queue.
module fetch_queue_unit import fetch_pkg::*; #(
    parameter int                XLEN     = XLEN_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = PC_INC_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                rst_n,
    fetch_queue_unit_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic              req;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // A request reserves a slot for its response, so the queue can never overflow.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign req  = rst_n && !bus.redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
    assign push = inflight && !bus.redirect_valid;
    assign pop  = bus.de_valid && bus.de_ready;

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = ADDR_W_DEF'(inflight_pc);
        push_entry.inst = XLEN_DEF'(bus.imem_rdata);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect_valid) begin
            pc       <= bus.redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= req;
            if (req) begin
                pc          <= pc + ADDR_W'(PC_INC);
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign bus.imem_req_valid = req;
    assign bus.imem_addr      = pc;
    assign bus.de_valid       = (count != '0);
    assign bus.de_inst        = XLEN'(head.inst);
    assign bus.de_pc          = ADDR_W'(head.pc);
    assign bus.de_rs1         = bus.de_inst[RS1_LSB +: REG_W];
    assign bus.de_rs2         = bus.de_inst[RS2_LSB +: REG_W];
    assign bus.de_rd          = bus.de_inst[RD_LSB +: REG_W];
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit against a queue-based reference model.
module tb_fetch_queue_unit;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int PC_INC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_queue_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    fetch_queue_unit #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PC_INC(PC_INC), .RESET_PC(32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [XLEN-1:0]   inst;
    } ent_t;

    ent_t              q[$];
    logic              pend;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] m_pc;
    int                n_cmp = 0;
    int                n_err = 0;

    function automatic logic [XLEN-1:0] inst_of(input logic [ADDR_W-1:0] a);
        return XLEN'(a + 32'h100);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend    = 1'b0;
        pend_pc = '0;
        m_pc    = '0;
    endtask

    // One clock cycle; entered and left just after a rising edge.
    task automatic step(input logic redir, input logic [ADDR_W-1:0] rpc, input logic rdy);
        logic              exp_req, exp_vld, exp_pop;
        logic [ADDR_W-1:0] issued;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.de_ready       = rdy;
        @(negedge clk);
        exp_vld = (q.size() != 0);
        exp_req = !redir && (q.size() + int'(pend) < DEPTH);
        chk("req_valid", bus.imem_req_valid, exp_req);
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("de_valid", bus.de_valid, exp_vld);
        if (exp_vld) begin
            chk("de_pc", bus.de_pc, q[0].pc);
            chk("de_inst", bus.de_inst, q[0].inst);
            chk("de_rs1", bus.de_rs1, q[0].inst[19:15]);
            chk("de_rs2", bus.de_rs2, q[0].inst[24:20]);
            chk("de_rd", bus.de_rd, q[0].inst[11:7]);
        end
        exp_pop = exp_vld && rdy;
        issued  = m_pc;
        @(posedge clk);
        if (exp_pop) void'(q.pop_front());
        if (redir) begin
            q.delete();
            pend = 1'b0;
            m_pc = rpc;
        end else begin
            if (pend) q.push_back('{pend_pc, inst_of(pend_pc)});
            pend    = exp_req;
            pend_pc = issued;
            if (exp_req) m_pc = m_pc + ADDR_W'(PC_INC);
        end
        #1;
        bus.imem_rdata = exp_req ? inst_of(issued) : XLEN'($urandom);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"}, bus.imem_req_valid, 1'b0);
        chk({tag, "_vld"}, bus.de_valid, 1'b0);
        chk({tag, "_addr"}, bus.imem_addr, 32'h0);
        chk({tag, "_pc"}, bus.de_pc, 32'h0);
        chk({tag, "_inst"}, bus.de_inst, 32'h0);
    endtask

    // Asserts reset between edges and checks the clear happens before any clock.
    task automatic async_reset();
        bus.redirect_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("arst");
        @(posedge clk);
        #1 check_zero("arst_hold");
        @(posedge clk);
        #1 rst_n = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.de_ready       = 1'b0;
        bus.imem_rdata     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming with decode always ready
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

        // Decode stalled: queue fills to DEPTH and requests stop
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
        chk("sat_count", dut.count, DEPTH);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        // Redirect with three entries queued
        begin
            bit hit = 1'b0;
            step(1'b1, 32'h40, 1'b0);
            for (int i = 0; i < 10 && !hit; i++) begin
                if (q.size() == 3) hit = 1'b1;
                else step(1'b0, '0, 1'b0);
            end
            chk("three_queued", hit, 1'b1);
            step(1'b1, 32'h2, 1'b0);
            for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        end

        // Redirect during steady pop+push, then back-to-back redirects
        step(1'b1, 32'h1000, 1'b1);
        step(1'b1, 32'h2000, 1'b1);
        step(1'b1, 32'h3000, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // PC wraps past the top of the address space
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        async_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                step(($urandom_range(0, 11) == 0), ADDR_W'($urandom), ($urandom_range(0, 3) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter XLEN, 32, instruction width in bits.
REQ-002 Parameter ADDR_W, 32, PC width in bits.
REQ-003 Parameter DEPTH, 4, instruction queue entries; power of two, at least 4.
REQ-004 Parameter PC_INC, 4, PC increment per sequential fetch.
REQ-005 Parameter RESET_PC, 0, first fetch address after reset.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 redirect_valid  input  1  branch taken; load redirect_pc and flush.
REQ-009 redirect_pc  input  ADDR_W  branch target.
REQ-010 imem_req_valid  output  1  fetch request this cycle.
REQ-011 imem_addr  output  ADDR_W  fetch address; equals current PC.
REQ-012 imem_rdata  input  XLEN  instruction word; valid exactly one cycle after imem_req_valid.
REQ-013 de_valid  output  1  queue head holds a valid instruction.
REQ-014 de_ready  input  1  decode accepts the head.
REQ-015 de_inst  output  XLEN  head instruction.
REQ-016 de_pc  output  ADDR_W  PC of head instruction.
REQ-017 de_rs1, de_rs2, de_rd  output  5 each  head inst[19:15], [24:20], [11:7].

Function
REQ-018 The block shall hold a PC register; each accepted request (imem_req_valid=1) shall advance PC by PC_INC, with modulo 2^ADDR_W wrap.
REQ-019 imem_req_valid shall be 1 when count + inflight < DEPTH and redirect_valid=0; count is the number of queued entries, and inflight is 0 or 1.
REQ-020 A response arriving one cycle after a live request shall be pushed with its request PC at the end of that cycle.
REQ-021 de_valid shall be driven from registered queue state, with no combinational path from imem_rdata.
REQ-022 Fetch-to-decode latency: a request issued in cycle k shall appear at the head with de_valid=1 in cycle k+2 when the queue was empty.
REQ-023 A pop shall occur when de_valid and de_ready are both 1; push and pop in the same cycle shall leave count unchanged.
REQ-024 With de_ready held at 1, sustained throughput shall be one instruction per cycle.
REQ-025 Entries shall be delivered strictly in fetch order.
REQ-026 The queue shall never overflow; when count=DEPTH, no push shall be possible because of REQ-019.
REQ-027 Redirect: in the redirect cycle, PC shall be loaded with redirect_pc, the queue emptied, and any inflight response discarded in the following cycle.
REQ-028 In the redirect cycle, no request shall be issued; the first fetch from redirect_pc shall occur in the next cycle.
REQ-029 A redirect coinciding with a pop shall let the pop complete; all remaining entries shall be flushed.
REQ-030 A redirect coinciding with a push shall drop the pushed entry.
REQ-031 Back-to-back redirects shall each take effect; the last one sets PC.
REQ-032 While de_valid=0, de_inst, de_pc and the de_rs*/de_rd fields are don't-care but shall not be X in simulation.

Reset
REQ-033 While rst_n=0: PC=RESET_PC, count=0, inflight=0, pointers=0, de_valid=0, imem_req_valid=0, and all data outputs 0.
REQ-034 Reset asserted mid-operation shall clear all state immediately, without waiting for clk.
REQ-035 imem_req_valid shall first assert in the first cycle after rst_n deasserts.

Structure
REQ-036 Package fetch_pkg shall hold the RS1/RS2/RD bit-position constants, the default XLEN/ADDR_W/PC_INC values, and the queue entry struct {pc, inst}.
REQ-037 The queue shall be a sub-module fetch_fifo (synchronous, DEPTH entries, flush input, count output); PC and credit logic shall sit in the top level.

Verification
REQ-038 Reset release, de_ready=1, imem returns addr+0x100 -> requests at PC 0,4,8,...; de_valid=1 from cycle 2; de_pc 0,4,8 one per cycle.
REQ-039 de_ready=0 for 10 cycles -> count saturates at 4, imem_req_valid=0 with inflight=0, no entry lost; on release, PCs stay contiguous.
REQ-040 Redirect to 0x2 at cycle 5 with 3 entries queued -> de_valid=0 in cycle 6; next request addr=0x2; the stale inflight word is never presented.
REQ-041 Redirect coinciding with pop and push -> exactly one pop counted, pushed entry dropped, queue empty.
REQ-042 rst_n pulsed low mid-stream -> outputs zero asynchronously; after release, fetch restarts at RESET_PC=0.
REQ-043 PC=0xFFFFFFFC, sequential fetch -> next imem_addr=0x00000000.
